// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for a single-port memory with a one-cycle read latency.
// The CPU wins contention until the DMA has lost MAX_WAIT times in a row.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic [2:0] {IDLE, GNT_CPU, GNT_DMA, RSP_CPU, RSP_DMA} state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  // Async reset on the state register makes every state-decoded output drop at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    dma_rvalid = 1'b0;
    cpu_rdata  = 8'h00;
    dma_rdata  = 8'h00;
    mem_addr   = 16'h0000;
    mem_wdata  = 8'h00;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && dma_req) begin
          if (wait_cnt_q == MAX_W) begin
            state_d    = GNT_DMA;
            wait_cnt_d = 4'd0;
          end else begin
            state_d    = GNT_CPU;
            wait_cnt_d = (wait_cnt_q >= MAX_W) ? MAX_W : wait_cnt_q + 4'd1;
          end
        end else if (cpu_req) begin
          state_d = GNT_CPU;
        end else if (dma_req) begin
          state_d    = GNT_DMA;
          wait_cnt_d = 4'd0;
        end
      end
      GNT_CPU: begin
        cpu_gnt   = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        state_d   = cpu_we ? IDLE : RSP_CPU;
      end
      GNT_DMA: begin
        dma_gnt   = 1'b1;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we;
        state_d   = dma_we ? IDLE : RSP_DMA;
      end
      RSP_CPU: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = mem_rdata;
        state_d    = IDLE;
      end
      RSP_DMA: begin
        dma_rvalid = 1'b1;
        dma_rdata  = mem_rdata;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; memory read data is a fixed function of the address.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we, busy;
  logic [7:0]  cpu_rdata, dma_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: data returned one cycle after the address, value = addr[7:0] ^ 0xC3.
  always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'hC3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Exclusivity invariants checked every falling edge outside reset.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("two_gnt", {31'd0, cpu_gnt & dma_gnt}, 32'd0);
      chk("two_rvalid", {31'd0, cpu_rvalid & dma_rvalid}, 32'd0);
      chk("we_outside_gnt", {31'd0, mem_we & ~(cpu_gnt | dma_gnt)}, 32'd0);
    end
  end

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wait", {28'd0, dut.wait_cnt_q}, 32'd0);
    chk("rst_outs", {28'd0, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}, 32'd0);
    chk("rst_mem", {7'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
    reset = 1'b0;

    // CPU write, DMA idle
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
    step();
    chk("wr_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'h2);
    chk("wr_mem", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, 1'b1, 16'h1234, 8'hA5});
    chk("wr_busy", {31'd0, busy}, 32'd1);
    cpu_req = 0;
    step();
    chk("wr_busy_end", {31'd0, busy}, 32'd0);
    chk("wr_idle_mem", {7'd0, mem_we, mem_addr, mem_wdata}, 32'd0);

    // DMA read of 0x00FF returns 0x3C the following cycle
    dma_req = 1; dma_we = 0; dma_addr = 16'h00FF;
    step();
    chk("dr_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'h1);
    chk("dr_mem", {15'd0, mem_we, mem_addr}, {15'd0, 1'b0, 16'h00FF});
    dma_req = 0;
    step();
    chk("dr_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'h1);
    chk("dr_rdata", {24'd0, dma_rdata}, 32'h3C);
    chk("dr_cpu_rdata", {24'd0, cpu_rdata}, 32'h0);
    chk("dr_rsp_busy", {31'd0, busy}, 32'd1);
    step();
    chk("dr_done", {29'd0, busy, cpu_rvalid, dma_rvalid}, 32'd0);

    // Fresh reset, then both ports read continuously: CPU,CPU,CPU,DMA repeating
    reset = 1'b1;
    #1;
    reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0020;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k % 4 == 3) begin
        chk("rr_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'h1);
        chk("rr_wait", {28'd0, dut.wait_cnt_q}, 32'd0);
      end else begin
        chk("rr_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'h2);
        chk("rr_wait", {28'd0, dut.wait_cnt_q}, 32'(k % 4 + 1));
      end
      step();
      if (k % 4 == 3) begin
        chk("rr_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'h1);
        chk("rr_rdata", {24'd0, dma_rdata}, 32'hE3);
      end else begin
        chk("rr_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'h2);
        chk("rr_rdata", {24'd0, cpu_rdata}, 32'hD3);
      end
      step();
      chk("rr_idle", {31'd0, busy}, 32'd0);
    end

    // CPU wins once (wait_cnt=1), then reset hits a DMA write in flight
    step();
    chk("pre_wait", {28'd0, dut.wait_cnt_q}, 32'd1);
    cpu_req = 0; dma_we = 1; dma_addr = 16'h0300; dma_wdata = 8'h5A;
    step();
    step();
    step();
    chk("ar_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'h1);
    chk("ar_we", {31'd0, mem_we}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_async", {29'd0, mem_we, dma_gnt, busy}, 32'd0);
    chk("ar_mem", {8'd0, mem_addr, mem_wdata}, 32'd0);
    dma_req = 0;
    step();
    reset = 1'b0;
    step();
    chk("ar_after", {29'd0, busy, cpu_rvalid, dma_rvalid}, 32'd0);
    chk("ar_wait", {28'd0, dut.wait_cnt_q}, 32'd0);

    // Alternating CPU read / DMA write
    for (int r = 0; r < 2; r++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0042;
      step();
      chk("alt_cgnt", {30'd0, cpu_gnt, dma_gnt}, 32'h2);
      cpu_req = 0;
      dma_req = 1; dma_we = 1; dma_addr = 16'h0400; dma_wdata = 8'h77;
      step();
      chk("alt_crsp", {30'd0, cpu_rvalid, dma_gnt}, 32'h2);
      chk("alt_crdata", {24'd0, cpu_rdata}, 32'h81);
      step();
      chk("alt_idle", {31'd0, busy}, 32'd0);
      step();
      chk("alt_dgnt", {30'd0, cpu_gnt, dma_gnt}, 32'h1);
      chk("alt_dmem", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, 1'b1, 16'h0400, 8'h77});
      dma_req = 0;
      step();
      chk("alt_dend", {29'd0, busy, dma_rvalid, mem_we}, 32'd0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
